// File: rtl/rnbip_reg_sequencer_pkg.sv
// Shared constants for the RNBIP-2 register-file sequencer.
// Holds the register-file command codes (enab), write-source codes (mux_sel),
// instruction class values, the NOP/HALT encodings and the FSM state type.
package rnbip_reg_sequencer_pkg;

  localparam logic [1:0] ENAB_IDLE  = 2'b00;
  localparam logic [1:0] ENAB_WRITE = 2'b01;
  localparam logic [1:0] ENAB_READ  = 2'b11;

  localparam logic [1:0] MUX_FEEDBACK = 2'b00;
  localparam logic [1:0] MUX_OR2      = 2'b10;
  localparam logic [1:0] MUX_ALU      = 2'b11;

  localparam logic [1:0] CLS_MVI = 2'b00;
  localparam logic [1:0] CLS_MOV = 2'b01;
  localparam logic [1:0] CLS_ALU = 2'b10;
  localparam logic [1:0] CLS_SYS = 2'b11;

  localparam logic [7:0] INSTR_NOP  = 8'hC0;
  localparam logic [7:0] INSTR_HALT = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_IMM,
    ST_WR_IMM,
    ST_RD_SRC,
    ST_WR_MOV,
    ST_ALU_WAIT,
    ST_WR_ALU,
    ST_HALT
  } state_t;

endpackage

// File: rtl/rnbip_reg_sequencer_alu_watchdog.sv
// alu_watchdog: clear/enable cycle counter with terminal-count flag.
// Ports: clk, rst_n (async active-low), clr (sync clear, has priority),
//        en (count up), tc (count has reached ALU_TIMEOUT-1, i.e. the
//        current enabled cycle is the ALU_TIMEOUT-th one).
module alu_watchdog #(
  parameter int unsigned ALU_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign tc = (count == 8'(ALU_TIMEOUT - 1));

endmodule

// File: rtl/rnbip_reg_sequencer.sv
// rnbip_reg_sequencer: byte-stream instruction sequencer driving the RNBIP-2
// register file (enab/seg/mux_sel/OR2) and handshaking with the ALU.
// Ports: clk, rst_n (async active-low); instr_valid/instr/instr_ready byte
//        handshake; OR2 immediate operand; enab/seg/mux_sel register-file
//        command; alu_op/alu_start/alu_done ALU handshake; halted, err pulse,
//        retired instruction counter.
module rnbip_reg_sequencer
  import rnbip_reg_sequencer_pkg::*;
#(
  parameter int unsigned ALU_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [7:0]  instr,
  output logic        instr_ready,
  output logic [7:0]  OR2,
  output logic [1:0]  enab,
  output logic [2:0]  seg,
  output logic [1:0]  mux_sel,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  output logic        halted,
  output logic        err,
  output logic [15:0] retired
);

  state_t     state, state_d;
  logic [2:0] rd_q;
  logic       is_alu_q;
  logic [1:0] enab_d, mux_d;
  logic [2:0] seg_d;
  logic       err_d, ret_inc, wd_clr, wd_en, wd_tc, accept;

  alu_watchdog #(.ALU_TIMEOUT(ALU_TIMEOUT)) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wd_clr),
    .en    (wd_en),
    .tc    (wd_tc)
  );

  assign instr_ready = (state == ST_FETCH) || (state == ST_IMM);
  assign accept      = instr_valid && instr_ready;
  assign halted      = (state == ST_HALT);
  assign alu_start   = (state == ST_RD_SRC) && is_alu_q;

  // enab/seg/mux_sel are computed for the state being entered and registered,
  // so they line up with that state while staying free of input paths.
  always_comb begin
    state_d = state;
    enab_d  = ENAB_IDLE;
    seg_d   = seg;
    mux_d   = mux_sel;
    err_d   = 1'b0;
    ret_inc = 1'b0;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    case (state)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (instr_valid) begin
          case (instr[7:6])
            CLS_MVI: state_d = ST_IMM;
            CLS_MOV, CLS_ALU: begin
              state_d = ST_RD_SRC;
              enab_d  = ENAB_READ;
              seg_d   = instr[2:0];
            end
            CLS_SYS: begin
              if (instr == INSTR_NOP) begin
                ret_inc = 1'b1;
              end else if (instr == INSTR_HALT) begin
                state_d = ST_HALT;
                ret_inc = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
          endcase
        end
      end
      ST_IMM: begin
        if (instr_valid) begin
          state_d = ST_WR_IMM;
          enab_d  = ENAB_WRITE;
          seg_d   = rd_q;
          mux_d   = MUX_OR2;
        end
      end
      ST_WR_IMM: begin
        state_d = ST_FETCH;
        ret_inc = 1'b1;
      end
      ST_RD_SRC: begin
        wd_clr = 1'b1;
        if (is_alu_q) begin
          state_d = ST_ALU_WAIT;
        end else begin
          state_d = ST_WR_MOV;
          enab_d  = ENAB_WRITE;
          seg_d   = rd_q;
          mux_d   = MUX_FEEDBACK;
        end
      end
      ST_WR_MOV: begin
        state_d = ST_FETCH;
        ret_inc = 1'b1;
      end
      ST_ALU_WAIT: begin
        wd_en = 1'b1;
        // done wins over a timeout expiring in the same cycle
        if (alu_done) begin
          state_d = ST_WR_ALU;
          enab_d  = ENAB_WRITE;
          seg_d   = 3'd0;
          mux_d   = MUX_ALU;
        end else if (wd_tc) begin
          state_d = ST_FETCH;
          err_d   = 1'b1;
        end
      end
      ST_WR_ALU: begin
        state_d = ST_FETCH;
        ret_inc = 1'b1;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enab     <= ENAB_IDLE;
      seg      <= '0;
      mux_sel  <= MUX_FEEDBACK;
      err      <= 1'b0;
      retired  <= '0;
      OR2      <= '0;
      alu_op   <= '0;
      rd_q     <= '0;
      is_alu_q <= 1'b0;
    end else begin
      enab    <= enab_d;
      seg     <= seg_d;
      mux_sel <= mux_d;
      err     <= err_d;
      if (ret_inc) begin
        retired <= retired + 16'd1;
      end
      if (accept && state == ST_IMM) begin
        OR2 <= instr;
      end
      if (accept && state == ST_FETCH) begin
        rd_q     <= (instr[7:6] == CLS_MVI) ? instr[2:0] : instr[5:3];
        is_alu_q <= (instr[7:6] == CLS_ALU);
        if (instr[7:6] == CLS_ALU) begin
          alu_op <= instr[5:3];
        end
      end
    end
  end

endmodule

// File: tb/tb_rnbip_reg_sequencer.sv
module tb_rnbip_reg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [7:0]  instr;
  logic        instr_ready;
  logic [7:0]  OR2;
  logic [1:0]  enab;
  logic [2:0]  seg;
  logic [1:0]  mux_sel;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic        halted;
  logic        err;
  logic [15:0] retired;

  int unsigned total = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  rnbip_reg_sequencer #(.ALU_TIMEOUT(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .OR2         (OR2),
    .enab        (enab),
    .seg         (seg),
    .mux_sel     (mux_sel),
    .alu_op      (alu_op),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .halted      (halted),
    .err         (err),
    .retired     (retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_or2"}, 32'(OR2), 32'h0);
    chk({tag, "_enab"}, 32'(enab), 32'h0);
    chk({tag, "_seg"}, 32'(seg), 32'h0);
    chk({tag, "_mux"}, 32'(mux_sel), 32'h0);
    chk({tag, "_aluop"}, 32'(alu_op), 32'h0);
    chk({tag, "_alustart"}, 32'(alu_start), 32'h0);
    chk({tag, "_ready"}, 32'(instr_ready), 32'h0);
    chk({tag, "_halted"}, 32'(halted), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_retired"}, 32'(retired), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = 8'h00; alu_done = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    chk("idle_ready", 32'(instr_ready), 32'h0);
    step();
    chk("fetch_ready", 32'(instr_ready), 32'h1);

    // MVI R5, 0x2A with a two-cycle stall in IMM
    instr_valid = 1'b1; instr = 8'h05;
    step();
    chk("imm_ready", 32'(instr_ready), 32'h1);
    chk("imm_enab", 32'(enab), 32'h0);
    instr_valid = 1'b0; instr = 8'h99;
    step(); step();
    chk("imm_stall_enab", 32'(enab), 32'h0);
    chk("imm_stall_or2", 32'(OR2), 32'h0);
    chk("imm_stall_ready", 32'(instr_ready), 32'h1);
    instr_valid = 1'b1; instr = 8'h2A;
    step();
    chk("wrimm_enab", 32'(enab), 32'h1);
    chk("wrimm_seg", 32'(seg), 32'h5);
    chk("wrimm_mux", 32'(mux_sel), 32'h2);
    chk("wrimm_or2", 32'(OR2), 32'h2A);
    instr_valid = 1'b0;
    step();
    chk("mvi_done_enab", 32'(enab), 32'h0);
    chk("mvi_retired", 32'(retired), 32'h1);
    chk("mvi_seg_hold", 32'(seg), 32'h5);
    chk("mvi_mux_hold", 32'(mux_sel), 32'h2);

    // MOV R3,R6 = 01_011_110
    instr_valid = 1'b1; instr = 8'h5E;
    step();
    chk("mov_rd_enab", 32'(enab), 32'h3);
    chk("mov_rd_seg", 32'(seg), 32'h6);
    chk("mov_rd_alustart", 32'(alu_start), 32'h0);
    chk("mov_rd_ready", 32'(instr_ready), 32'h0);
    instr_valid = 1'b0;
    step();
    chk("mov_wr_enab", 32'(enab), 32'h1);
    chk("mov_wr_seg", 32'(seg), 32'h3);
    chk("mov_wr_mux", 32'(mux_sel), 32'h0);
    step();
    chk("mov_retired", 32'(retired), 32'h2);
    chk("mov_or2_hold", 32'(OR2), 32'h2A);

    // ALU op 2, R4 = 10_010_100; alu_done 3 cycles after alu_start
    instr_valid = 1'b1; instr = 8'h94;
    step();
    chk("alu_rd_enab", 32'(enab), 32'h3);
    chk("alu_rd_seg", 32'(seg), 32'h4);
    chk("alu_start", 32'(alu_start), 32'h1);
    chk("alu_op", 32'(alu_op), 32'h2);
    instr_valid = 1'b0;
    step();
    chk("alu_wait_start", 32'(alu_start), 32'h0);
    chk("alu_wait_enab", 32'(enab), 32'h0);
    step(); step();
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    chk("wralu_enab", 32'(enab), 32'h1);
    chk("wralu_seg", 32'(seg), 32'h0);
    chk("wralu_mux", 32'(mux_sel), 32'h3);
    chk("wralu_err", 32'(err), 32'h0);
    step();
    chk("alu_retired", 32'(retired), 32'h3);
    chk("alu_err", 32'(err), 32'h0);

    // ALU op 1, R2 with no alu_done: err 6 cycles after entering ALU_WAIT
    instr_valid = 1'b1; instr = 8'h8A;
    step();
    instr_valid = 1'b0;
    step();
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("to_wait_err%0d", i), 32'(err), 32'h0);
      chk($sformatf("to_wait_ready%0d", i), 32'(instr_ready), 32'h0);
    end
    step();
    chk("to_err", 32'(err), 32'h1);
    chk("to_ready", 32'(instr_ready), 32'h1);
    chk("to_retired", 32'(retired), 32'h3);
    step();
    chk("to_err_pulse", 32'(err), 32'h0);

    // alu_done on the same cycle the timeout expires counts as done
    instr_valid = 1'b1; instr = 8'h8A;
    step();
    instr_valid = 1'b0;
    step();
    repeat (5) step();
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    chk("late_done_enab", 32'(enab), 32'h1);
    chk("late_done_err", 32'(err), 32'h0);
    step();
    chk("late_done_retired", 32'(retired), 32'h4);
    chk("late_done_err2", 32'(err), 32'h0);

    // back-to-back NOPs
    instr_valid = 1'b1; instr = 8'hC0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("nop_ready%0d", i), 32'(instr_ready), 32'h1);
      chk($sformatf("nop_retired%0d", i), 32'(retired), 32'(5 + i));
    end

    // illegal then HALT
    instr = 8'hC5;
    step();
    chk("illegal_err", 32'(err), 32'h1);
    chk("illegal_retired", 32'(retired), 32'h7);
    instr = 8'hFF;
    step();
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_ready", 32'(instr_ready), 32'h0);
    chk("halt_err", 32'(err), 32'h0);
    chk("halt_retired", 32'(retired), 32'h8);
    instr = 8'h05;
    repeat (3) step();
    chk("halt_stay", 32'(halted), 32'h1);
    chk("halt_enab", 32'(enab), 32'h0);
    chk("halt_retired2", 32'(retired), 32'h8);

    // reset pulse exits HALT
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("halt_rst_halted", 32'(halted), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_halt_ready", 32'(instr_ready), 32'h1);

    // reset during IMM with instr_valid held high
    instr_valid = 1'b1; instr = 8'h03;
    step();
    instr = 8'h77;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("imm_rst");
    @(negedge clk);
    rst_n = 1'b1;
    chk("imm_rst_idle_ready", 32'(instr_ready), 32'h0);
    step();
    chk("imm_rst_fetch_ready", 32'(instr_ready), 32'h1);
    chk("imm_rst_no_write", 32'(enab), 32'h0);
    chk("imm_rst_or2", 32'(OR2), 32'h0);
    instr_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
